ebpc_stream_merger: RTL and testbench



---
 rtl/ebpc_stream_merger.sv | 192 +++++++++++++++++++
 tb/tb_ebpc_stream_merger.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebpc_stream_merger.sv
// Tagged round-robin merge of the EBPC ZNZ and BPC streams, followed by a
// per-frame trailer carrying both streams' word counts.
package ebpc_pkg;
  parameter int unsigned DATA_W = 8;
endpackage

module ebpc_stream_merger_chk #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) ();
  // The trailer slices the counters into whole words.
  if ((CNT_W % DATA_W) != 0) begin : g_cnt_w_check
    $error("ebpc_stream_merger: CNT_W must be a multiple of DATA_W");
  end
endmodule

module ebpc_stream_merger #(
  parameter int unsigned DATA_W = ebpc_pkg::DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] znz_data_i,
  input  logic              znz_last_i,
  input  logic              znz_vld_i,
  output logic              znz_rdy_o,
  input  logic [DATA_W-1:0] bpc_data_i,
  input  logic              bpc_last_i,
  input  logic              bpc_vld_i,
  output logic              bpc_rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        tag_o,
  output logic              last_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              idle_o,
  output logic              overflow_o
);

  localparam int unsigned       N_TR    = 2 * CNT_W / DATA_W;
  localparam int unsigned       TR_W    = (N_TR > 1) ? $clog2(N_TR) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TR_W-1:0]   TR_LAST = TR_W'(N_TR - 1);
  localparam logic [1:0]        TAG_ZNZ = 2'b00;
  localparam logic [1:0]        TAG_BPC = 2'b01;
  localparam logic [1:0]        TAG_TRL = 2'b10;

  typedef enum logic {COLLECT = 1'b0, TRAILER = 1'b1} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_MAX) begin
      return cnt;
    end else begin
      return cnt + CNT_W'(1);
    end
  endfunction

  function automatic logic [DATA_W-1:0] trailer_chunk(input logic [2*CNT_W-1:0] cat,
                                                      input logic [TR_W-1:0]    idx);
    return cat[int'(idx)*DATA_W +: DATA_W];
  endfunction

  state_e              state_r;
  logic                znz_done_r, bpc_done_r, prio_r;
  logic [CNT_W-1:0]    znz_cnt_r, bpc_cnt_r;
  logic [TR_W-1:0]     tr_idx_r;
  logic [DATA_W-1:0]   data_r;
  logic [1:0]          tag_r;
  logic                last_r, vld_r, overflow_r;

  logic                load_en_s;
  logic                znz_elig_s, bpc_elig_s;
  logic                znz_grant_s, bpc_grant_s;
  logic                znz_acc_s, bpc_acc_s;
  logic                znz_done_nxt_s, bpc_done_nxt_s;
  logic [CNT_W-1:0]    znz_cnt_inc_s, bpc_cnt_inc_s;
  logic                tr_final_s, ovf_set_s, ovf_clr_s;

  ebpc_stream_merger_chk #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_chk ();

  assign load_en_s      = !vld_r || rdy_i;
  assign znz_elig_s     = znz_vld_i && !znz_done_r;
  assign bpc_elig_s     = bpc_vld_i && !bpc_done_r;
  assign znz_acc_s      = znz_grant_s && load_en_s;
  assign bpc_acc_s      = bpc_grant_s && load_en_s;
  assign znz_done_nxt_s = znz_done_r || (znz_acc_s && znz_last_i);
  assign bpc_done_nxt_s = bpc_done_r || (bpc_acc_s && bpc_last_i);
  assign znz_cnt_inc_s  = sat_inc(znz_cnt_r);
  assign bpc_cnt_inc_s  = sat_inc(bpc_cnt_r);
  assign tr_final_s     = (tr_idx_r == TR_LAST);
  assign ovf_set_s      = (znz_acc_s && (znz_cnt_inc_s == CNT_MAX)) ||
                          (bpc_acc_s && (bpc_cnt_inc_s == CNT_MAX));
  assign ovf_clr_s      = vld_r && rdy_i && last_r;

  // Round-robin grant between the eligible streams while collecting.
  always_comb begin
    znz_grant_s = 1'b0;
    bpc_grant_s = 1'b0;
    if (state_r == COLLECT) begin
      if (znz_elig_s && bpc_elig_s) begin
        znz_grant_s = !prio_r;
        bpc_grant_s = prio_r;
      end else begin
        znz_grant_s = znz_elig_s;
        bpc_grant_s = bpc_elig_s;
      end
    end else begin
      znz_grant_s = 1'b0;
      bpc_grant_s = 1'b0;
    end
  end

  // Frame state machine, per-stream bookkeeping and the output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= COLLECT;
      znz_done_r <= 1'b0;
      bpc_done_r <= 1'b0;
      prio_r     <= 1'b0;
      znz_cnt_r  <= '0;
      bpc_cnt_r  <= '0;
      tr_idx_r   <= '0;
      data_r     <= '0;
      tag_r      <= 2'b00;
      last_r     <= 1'b0;
      vld_r      <= 1'b0;
    end else if (state_r == COLLECT) begin
      if (znz_acc_s) begin
        data_r     <= znz_data_i;
        tag_r      <= TAG_ZNZ;
        last_r     <= 1'b0;
        vld_r      <= 1'b1;
        znz_cnt_r  <= znz_cnt_inc_s;
        prio_r     <= 1'b1;
        znz_done_r <= znz_done_nxt_s;
      end else if (bpc_acc_s) begin
        data_r     <= bpc_data_i;
        tag_r      <= TAG_BPC;
        last_r     <= 1'b0;
        vld_r      <= 1'b1;
        bpc_cnt_r  <= bpc_cnt_inc_s;
        prio_r     <= 1'b0;
        bpc_done_r <= bpc_done_nxt_s;
      end else if (load_en_s) begin
        last_r <= 1'b0;
        vld_r  <= 1'b0;
      end
      // Switch as the second last word lands so the trailer follows without a bubble.
      if (znz_done_nxt_s && bpc_done_nxt_s) begin
        state_r <= TRAILER;
      end
    end else if (load_en_s) begin
      data_r <= trailer_chunk({bpc_cnt_r, znz_cnt_r}, tr_idx_r);
      tag_r  <= TAG_TRL;
      last_r <= tr_final_s;
      vld_r  <= 1'b1;
      if (tr_final_s) begin
        state_r    <= COLLECT;
        znz_done_r <= 1'b0;
        bpc_done_r <= 1'b0;
        prio_r     <= 1'b0;
        znz_cnt_r  <= '0;
        bpc_cnt_r  <= '0;
        tr_idx_r   <= '0;
      end else begin
        tr_idx_r <= tr_idx_r + TR_W'(1);
      end
    end
  end

  // Sticky saturation flag, held until the frame's final trailer word leaves.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_r <= 1'b0;
    end else if (ovf_set_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr_s) begin
      overflow_r <= 1'b0;
    end
  end

  assign znz_rdy_o  = znz_acc_s;
  assign bpc_rdy_o  = bpc_acc_s;
  assign data_o     = data_r;
  assign tag_o      = tag_r;
  assign last_o     = last_r;
  assign vld_o      = vld_r;
  assign overflow_o = overflow_r;
  assign idle_o     = (state_r == COLLECT) && !znz_done_r && !bpc_done_r && !vld_r &&
                      (znz_cnt_r == '0) && (bpc_cnt_r == '0);

endmodule

// File: tb/tb_ebpc_stream_merger.sv
// Directed bench for ebpc_stream_merger: a CNT_W=16 instance for most scenarios
// and a CNT_W=8 instance for counter saturation, selected by sel8.
module tb_ebpc_stream_merger;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] znz_data, bpc_data;
  logic       znz_last, znz_vld, bpc_last, bpc_vld, rdy_i, sel8;

  logic       r16z, r16b, l16, v16, i16, o16;
  logic [7:0] d16;
  logic [1:0] t16;
  logic       r8z, r8b, l8, v8, i8, o8;
  logic [7:0] d8;
  logic [1:0] t8;

  logic       zv16, bv16, zv8, bv8;
  logic       rdy_z, rdy_b, mv, ml, m_idle, m_ovf;
  logic [7:0] md;
  logic [1:0] mt;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] out_q[$];
  bit          tr_done;
  bit          stall_p;
  logic [11:0] held;

  assign zv16   = znz_vld && !sel8;
  assign bv16   = bpc_vld && !sel8;
  assign zv8    = znz_vld && sel8;
  assign bv8    = bpc_vld && sel8;
  assign rdy_z  = sel8 ? r8z : r16z;
  assign rdy_b  = sel8 ? r8b : r16b;
  assign mv     = sel8 ? v8 : v16;
  assign ml     = sel8 ? l8 : l16;
  assign md     = sel8 ? d8 : d16;
  assign mt     = sel8 ? t8 : t16;
  assign m_idle = sel8 ? i8 : i16;
  assign m_ovf  = sel8 ? o8 : o16;

  ebpc_stream_merger #(.DATA_W(8), .CNT_W(16)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_ni),
    .znz_data_i(znz_data), .znz_last_i(znz_last), .znz_vld_i(zv16), .znz_rdy_o(r16z),
    .bpc_data_i(bpc_data), .bpc_last_i(bpc_last), .bpc_vld_i(bv16), .bpc_rdy_o(r16b),
    .data_o(d16), .tag_o(t16), .last_o(l16), .vld_o(v16), .rdy_i(rdy_i),
    .idle_o(i16), .overflow_o(o16));

  ebpc_stream_merger #(.DATA_W(8), .CNT_W(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_ni),
    .znz_data_i(znz_data), .znz_last_i(znz_last), .znz_vld_i(zv8), .znz_rdy_o(r8z),
    .bpc_data_i(bpc_data), .bpc_last_i(bpc_last), .bpc_vld_i(bv8), .bpc_rdy_o(r8b),
    .data_o(d8), .tag_o(t8), .last_o(l8), .vld_o(v8), .rdy_i(rdy_i),
    .idle_o(i8), .overflow_o(o8));

  always #5 clk = ~clk;

  // Output monitor: records handshakes, checks stall stability and trailer overflow.
  always @(negedge clk) begin
    if (!rst_ni) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        checks++;
        if ({md, mt, ml, mv} !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h expected %h", {md, mt, ml, mv}, held);
        end
      end
      if (mv && !rdy_i) begin
        checks++;
        if (rdy_z || rdy_b) begin
          errors++;
          $display("FAIL stall_rdy: got znz_rdy=%b bpc_rdy=%b expected 0 0", rdy_z, rdy_b);
        end
      end
      if (mv && rdy_i) begin
        out_q.push_back({ml, mt, md});
        if (ml) begin
          tr_done = 1'b1;
          if (sel8) begin
            checks++;
            if (m_ovf !== 1'b1) begin
              errors++;
              $display("FAIL sat_ovf_before_last: got %b expected 1", m_ovf);
            end
          end
        end
      end
      stall_p = mv && !rdy_i;
      held    = {md, mt, ml, mv};
    end
  end

  task automatic do_reset();
    rst_ni = 1'b0; znz_vld = 1'b0; bpc_vld = 1'b0; rdy_i = 1'b1;
    znz_data = 8'h00; bpc_data = 8'h00; znz_last = 1'b0; bpc_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // order: 0 both free, 1 BPC waits for ZNZ last, 2 ZNZ waits for BPC last.
  task automatic run(input int nz, input int nb, input logic [7:0] zb, input logic [7:0] bb,
                     input int order, input bit bp, input int stop_acc, input bit hold_b);
    int  zi = 0;
    int  bi = 0;
    bit  finished = 1'b0;
    out_q.delete();
    tr_done = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(posedge clk); #1;
      if (tr_done || (stop_acc > 0 && zi + bi >= stop_acc)) begin
        finished = 1'b1;
        break;
      end
      rdy_i    = bp ? (cyc % 2 == 0) : 1'b1;
      znz_vld  = (zi < nz) && !(order == 2 && bi < nb);
      znz_data = zb + 8'(zi * 17);
      znz_last = (zi == nz - 1);
      if (bi < nb) begin
        bpc_vld  = !(order == 1 && zi < nz);
        bpc_data = bb + 8'(bi * 17);
        bpc_last = (bi == nb - 1);
      end else begin
        bpc_vld  = hold_b && !(mv && ml);
        bpc_data = 8'hEE;
        bpc_last = 1'b1;
      end
      @(negedge clk);
      if (znz_vld && rdy_z) zi++;
      if (hold_b && bi >= nb && !tr_done) begin
        checks++;
        if (rdy_b !== 1'b0) begin
          errors++;
          $display("FAIL early_bpc_rdy: got %b expected 0", rdy_b);
        end
      end
      if (bi < nb && bpc_vld && rdy_b) bi++;
    end
    znz_vld = 1'b0; bpc_vld = 1'b0; rdy_i = 1'b1;
    if (!finished) begin
      checks++; errors++;
      $display("FAIL run_timeout: got %0d words expected frame completion", out_q.size());
    end
  endtask

  task automatic test_reset();
    sel8 = 1'b0;
    do_reset();
    checks++;
    if ({v16, l16, t16, d16, o16, i16, r16z, r16b} !== {1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got vld=%b last=%b tag=%b data=%h ovf=%b idle=%b rdys=%b%b expected 0 0 00 00 0 1 00",
               v16, l16, t16, d16, o16, i16, r16z, r16b);
    end
    checks++;
    if ({v8, o8, i8} !== 3'b001) begin
      errors++;
      $display("FAIL reset_state8: got vld=%b ovf=%b idle=%b expected 0 0 1", v8, o8, i8);
    end
  endtask

  task automatic test_znz_then_bpc();
    logic [10:0] exp[$];
    exp = '{{1'b0, 2'b00, 8'h11}, {1'b0, 2'b00, 8'h22}, {1'b0, 2'b01, 8'h33},
            {1'b0, 2'b10, 8'h02}, {1'b0, 2'b10, 8'h00}, {1'b0, 2'b10, 8'h01},
            {1'b1, 2'b10, 8'h00}};
    run(2, 1, 8'h11, 8'h33, 1, 1'b0, 0, 1'b0);
    checks++;
    if (out_q.size() != exp.size()) begin
      errors++;
      $display("FAIL seq_count: got %0d expected %0d", out_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL seq_word%0d: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 11'h7FF, exp[i]);
      end
    end
    checks++;
    if (i16 !== 1'b1) begin
      errors++;
      $display("FAIL seq_idle_after: got %b expected 1", i16);
    end
  endtask

  task automatic test_interleave(input bit bp);
    logic [10:0] exp[$];
    exp = '{{1'b0, 2'b00, 8'h10}, {1'b0, 2'b01, 8'h80}, {1'b0, 2'b00, 8'h21},
            {1'b0, 2'b01, 8'h91}, {1'b0, 2'b00, 8'h32}, {1'b0, 2'b01, 8'hA2},
            {1'b0, 2'b10, 8'h03}, {1'b0, 2'b10, 8'h00}, {1'b0, 2'b10, 8'h03},
            {1'b1, 2'b10, 8'h00}};
    run(3, 3, 8'h10, 8'h80, 0, bp, 0, 1'b0);
    checks++;
    if (out_q.size() != exp.size()) begin
      errors++;
      $display("FAIL ilv_count bp=%0d: got %0d expected %0d", bp, out_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL ilv_word%0d bp=%0d: got %h expected %h", i, bp, (i < out_q.size()) ? out_q[i] : 11'h7FF, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    test_interleave(1'b0);
    test_interleave(1'b1);
  endtask

  task automatic test_early_last();
    logic [10:0] exp[$];
    exp = '{{1'b0, 2'b01, 8'h55}, {1'b0, 2'b00, 8'h01}, {1'b0, 2'b00, 8'h12},
            {1'b0, 2'b00, 8'h23}, {1'b0, 2'b00, 8'h34}, {1'b0, 2'b10, 8'h04},
            {1'b0, 2'b10, 8'h00}, {1'b0, 2'b10, 8'h01}, {1'b1, 2'b10, 8'h00}};
    run(4, 1, 8'h01, 8'h55, 2, 1'b0, 0, 1'b1);
    checks++;
    if (out_q.size() != exp.size()) begin
      errors++;
      $display("FAIL early_count: got %0d expected %0d", out_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL early_word%0d: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 11'h7FF, exp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [10:0] exp[$];
    sel8 = 1'b1;
    do_reset();
    for (int i = 0; i < 300; i++) exp.push_back({1'b0, 2'b00, 8'(i * 17)});
    exp.push_back({1'b0, 2'b01, 8'h77});
    exp.push_back({1'b0, 2'b10, 8'hFF});
    exp.push_back({1'b1, 2'b10, 8'h01});
    run(300, 1, 8'h00, 8'h77, 1, 1'b0, 0, 1'b0);
    checks++;
    if (out_q.size() != exp.size()) begin
      errors++;
      $display("FAIL sat_count: got %0d expected %0d", out_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL sat_word%0d: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 11'h7FF, exp[i]);
      end
    end
    checks++;
    if (o8 !== 1'b0) begin
      errors++;
      $display("FAIL sat_ovf_after: got %b expected 0", o8);
    end
    sel8 = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] exp[$];
    exp = '{{1'b0, 2'b00, 8'hA0}, {1'b0, 2'b01, 8'hB0}, {1'b0, 2'b10, 8'h01},
            {1'b0, 2'b10, 8'h00}, {1'b0, 2'b10, 8'h01}, {1'b1, 2'b10, 8'h00}};
    sel8 = 1'b0;
    do_reset();
    run(10, 10, 8'h40, 8'hC0, 0, 1'b0, 5, 1'b0);
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({v16, i16, r16z, r16b} !== 4'b0100) begin
      errors++;
      $display("FAIL rst_mid: got vld=%b idle=%b rdys=%b%b expected 0 1 00", v16, i16, r16z, r16b);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    run(1, 1, 8'hA0, 8'hB0, 0, 1'b0, 0, 1'b0);
    checks++;
    if (out_q.size() != exp.size()) begin
      errors++;
      $display("FAIL rst_count: got %0d expected %0d", out_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL rst_word%0d: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 11'h7FF, exp[i]);
      end
    end
  endtask

  initial begin
    sel8 = 1'b0;
    test_reset();
    test_znz_then_bpc();
    test_back_to_back();
    test_early_last();
    test_saturation();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
